// File: rtl/circular_dma_pkg.sv
// Shared types and helpers for the circular DMA reader: FSM states, irq bit map
// and burst sizing.
package circular_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_ADDR  = 2'd1,
        ST_DATA_BURST = 2'd2
    } reader_state_e;

    localparam int unsigned IRQ_W       = 3;
    localparam int unsigned IRQ_DRAINED = 0;
    localparam int unsigned IRQ_WRAP    = 1;
    localparam int unsigned IRQ_ERROR   = 2;

    // Bytes moved by one full-length burst.
    function automatic int unsigned burst_bytes(input int unsigned max_burst,
                                                input int unsigned axis_width);
        return max_burst * (axis_width / 8);
    endfunction

endpackage

// File: rtl/circular_dma_burst_len.sv
// Combinational burst sizing: beats available in the ring, clipped by the
// max burst, downstream FIFO space and the next burst-aligned boundary.
module circular_dma_burst_len
    import circular_dma_pkg::*;
#(
    parameter int unsigned C_AXIS_WIDTH       = 64,
    parameter int unsigned C_MAX_BURST        = 16,
    parameter int unsigned C_AXIS_OCCUP_WIDTH = 16
) (
    input  logic [31:0]                   wr_ptr,
    input  logic [31:0]                   rd_ptr,
    input  logic [31:0]                   mem_size,
    input  logic [C_AXIS_OCCUP_WIDTH-1:0] fifo_free,
    output logic [31:0]                   len_c,
    output logic [31:0]                   avail_c,
    output logic                          no_wrap_c
);

    localparam int unsigned BEAT_BYTES  = C_AXIS_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int unsigned BURST_BYTES = burst_bytes(C_MAX_BURST, C_AXIS_WIDTH);

    logic [31:0] wr_aligned;
    logic [31:0] span_bytes;
    logic [31:0] to_bound;

    always_comb begin
        wr_aligned = wr_ptr & ~(32'(BEAT_BYTES) - 32'd1);
        no_wrap_c  = (wr_aligned >= rd_ptr);
        // When the producer is behind us, only read up to the end of the buffer.
        span_bytes = no_wrap_c ? (wr_aligned - rd_ptr) : (mem_size - rd_ptr);
        avail_c    = span_bytes >> BEAT_SHIFT;
        to_bound   = (32'(BURST_BYTES) - (rd_ptr % 32'(BURST_BYTES))) >> BEAT_SHIFT;

        len_c = 32'(C_MAX_BURST);
        if (avail_c < len_c) begin
            len_c = avail_c;
        end
        if (32'(fifo_free) < len_c) begin
            len_c = 32'(fifo_free);
        end
        if (to_bound < len_c) begin
            len_c = to_bound;
        end
    end

endmodule

// File: rtl/circular_dma_reader.sv
// Reads a circular memory buffer over AXI and streams it out; tracks the
// consumer pointer, wrap/drain/error interrupts and last response status.
module circular_dma_reader
    import circular_dma_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH       = 32,
    parameter int unsigned C_AXIS_WIDTH       = 64,
    parameter int unsigned C_MAX_BURST        = 16,
    parameter int unsigned C_AXIS_OCCUP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [2:0]                    clear_irq,
    input  logic [2:0]                    enable_irq,
    output logic [2:0]                    irq,
    output logic [2:0]                    status_flags,
    input  logic [C_ADDR_WIDTH-1:0]       mem_base,
    input  logic [31:0]                   mem_size,
    input  logic [31:0]                   wr_ptr,
    output logic [31:0]                   rd_ptr,
    input  logic [C_AXIS_OCCUP_WIDTH-1:0] fifo_free,
    output logic [C_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXIS_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [C_AXIS_WIDTH-1:0]       m_axis_mm2s_tdata,
    output logic                          m_axis_mm2s_tlast,
    output logic                          m_axis_mm2s_tvalid,
    input  logic                          m_axis_mm2s_tready
);

    localparam int unsigned BEAT_BYTES  = C_AXIS_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int unsigned BURST_BYTES = burst_bytes(C_MAX_BURST, C_AXIS_WIDTH);

    reader_state_e           state_q, state_d;
    logic [31:0]             rd_ptr_q, rd_ptr_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic [IRQ_W-1:0]        irq_q, irq_d;
    logic [2:0]              status_q, status_d;
    logic                    err_q, err_d;
    logic                    err_resp0_q, err_resp0_d;
    logic                    last_burst_q, last_burst_d;

    logic [31:0] len_c;
    logic [31:0] avail_c;
    logic        no_wrap_c;
    logic [31:0] next_rd_c;
    logic        beat_fire_c;
    logic        beat_err_c;
    logic        resp0_c;

    circular_dma_burst_len #(
        .C_AXIS_WIDTH      (C_AXIS_WIDTH),
        .C_MAX_BURST       (C_MAX_BURST),
        .C_AXIS_OCCUP_WIDTH(C_AXIS_OCCUP_WIDTH)
    ) u_burst_len (
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr_q),
        .mem_size (mem_size),
        .fifo_free(fifo_free),
        .len_c    (len_c),
        .avail_c  (avail_c),
        .no_wrap_c(no_wrap_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            irq_q        <= '0;
            status_q     <= 3'b001;
            err_q        <= 1'b0;
            err_resp0_q  <= 1'b0;
            last_burst_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            irq_q        <= irq_d;
            status_q     <= status_d;
            err_q        <= err_d;
            err_resp0_q  <= err_resp0_d;
            last_burst_q <= last_burst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        status_d     = status_q;
        err_d        = err_q;
        err_resp0_d  = err_resp0_q;
        last_burst_d = last_burst_q;
        irq_d        = irq_q & ~clear_irq & enable_irq;

        m_axis_mm2s_tdata  = m_axi_rdata;
        m_axis_mm2s_tvalid = 1'b0;
        m_axis_mm2s_tlast  = 1'b0;
        m_axi_rready       = 1'b0;

        beat_fire_c = m_axi_rvalid & m_axis_mm2s_tready;
        beat_err_c  = m_axi_rresp[1];
        resp0_c     = beat_err_c ? m_axi_rresp[0] : err_resp0_q;
        next_rd_c   = rd_ptr_q + ((32'(arlen_q) + 32'd1) << BEAT_SHIFT);

        case (state_q)
            ST_IDLE: begin
                if (enable && (irq_q == '0) && (mem_size >= 32'(BURST_BYTES))) begin
                    state_d     = ST_READ_ADDR;
                    rd_ptr_d    = '0;
                    status_d    = 3'b001;
                    err_d       = 1'b0;
                    err_resp0_d = 1'b0;
                end
            end

            ST_READ_ADDR: begin
                if (arvalid_q) begin
                    if (m_axi_arready) begin
                        arvalid_d = 1'b0;
                        state_d   = ST_DATA_BURST;
                    end
                end else if (len_c != '0) begin
                    araddr_d     = mem_base + C_ADDR_WIDTH'(rd_ptr_q);
                    arlen_d      = 8'(len_c - 32'd1);
                    arvalid_d    = 1'b1;
                    last_burst_d = (len_c == avail_c) && no_wrap_c;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA_BURST: begin
                m_axis_mm2s_tvalid = m_axi_rvalid;
                m_axis_mm2s_tlast  = m_axi_rlast & last_burst_q;
                m_axi_rready       = m_axis_mm2s_tready;

                if (beat_fire_c) begin
                    if (beat_err_c) begin
                        err_d       = 1'b1;
                        err_resp0_d = m_axi_rresp[0];
                    end
                    // Burst end: commit the pointer, or freeze it on any error beat.
                    if (m_axi_rlast) begin
                        if (err_q || beat_err_c) begin
                            irq_d[IRQ_ERROR] = enable_irq[IRQ_ERROR];
                            status_d         = {resp0_c, ~resp0_c, 1'b0};
                            state_d          = ST_IDLE;
                        end else begin
                            if (next_rd_c == mem_size) begin
                                rd_ptr_d        = '0;
                                irq_d[IRQ_WRAP] = enable_irq[IRQ_WRAP];
                            end else begin
                                rd_ptr_d = next_rd_c;
                            end
                            if (last_burst_q) begin
                                irq_d[IRQ_DRAINED] = enable_irq[IRQ_DRAINED];
                            end
                            state_d = enable ? ST_READ_ADDR : ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign irq           = irq_q;
    assign status_flags  = status_q;
    assign rd_ptr        = rd_ptr_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;

endmodule
